// File: rtl/song_sequencer.sv
// Song note sequencer: walks the note ROM one entry per beat, absorbs the ROM's
// registered read latency and hands each note to the scroll logic with a valid strobe.
module song_sequencer #(
   parameter int SONG_LEN = 94,
   parameter int ADDR_W   = 7,
   parameter int NOTE_W   = 5,
   parameter int BEAT_DIV = 12_500_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [NOTE_W-1:0] rom_data,
   output logic [NOTE_W-1:0] note,
   output logic              note_valid,
   output logic              beat_tick,
   output logic              playing,
   output logic              done
);

   localparam int CNT_W = $clog2(BEAT_DIV);
   // FETCH and LATCH eat two cycles of the beat, so HOLD ends at BEAT_DIV-3.
   localparam logic [CNT_W-1:0]  TICK_AT = CNT_W'(BEAT_DIV - 3);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SONG_LEN - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, HOLD, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] beat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_addr   <= '0;
         note       <= '0;
         note_valid <= 1'b0;
         beat_tick  <= 1'b0;
         playing    <= 1'b0;
         done       <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         note_valid <= 1'b0;
         beat_tick  <= 1'b0;
         if (abort) begin
            state    <= IDLE;
            rom_addr <= '0;
            note     <= '0;
            beat_cnt <= '0;
            playing  <= 1'b0;
            done     <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state    <= FETCH;
                  rom_addr <= '0;
                  playing  <= 1'b1;
               end
               FETCH: state <= LATCH;
               LATCH: begin
                  note       <= rom_data;
                  note_valid <= 1'b1;
                  beat_cnt   <= '0;
                  state      <= HOLD;
               end
               HOLD: if (!pause) begin
                  if (beat_cnt == TICK_AT) begin
                     beat_tick <= 1'b1;
                     if (rom_addr == LAST) begin
                        state   <= DONE;
                        playing <= 1'b0;
                     end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        state    <= FETCH;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
               DONE: if (start) begin
                  state    <= FETCH;
                  rom_addr <= '0;
                  playing  <= 1'b1;
                  done     <= 1'b0;
               end else begin
                  note <= '0;
                  done <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a 4-note instance for control scenarios and
// a 94-note instance for full-length playback, both with BEAT_DIV=8.
module tb_song_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, pause = 1'b0, abort = 1'b0, start_f = 1'b0;
   logic [6:0] rom_addr, rom_addr_f;
   logic [4:0] rom_data, rom_data_f, note, note_f;
   logic       note_valid, beat_tick, playing, done;
   logic       note_valid_f, beat_tick_f, playing_f, done_f;

   logic [4:0] rom4 [128];
   logic [4:0] romf [128];

   typedef struct {int cyc; int nt;} ev_t;
   ev_t qn[$];
   ev_t qf[$];
   int  qt[$];

   int ecnt = 0;
   int n_cmp = 0, n_err = 0;
   int maxaddr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   song_sequencer #(.SONG_LEN(4), .BEAT_DIV(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
      .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .note_valid(note_valid),
      .beat_tick(beat_tick), .playing(playing), .done(done));

   song_sequencer #(.SONG_LEN(94), .BEAT_DIV(8)) u_full (
      .clk(clk), .rst_n(rst_n), .start(start_f), .pause(1'b0), .abort(1'b0),
      .rom_addr(rom_addr_f), .rom_data(rom_data_f), .note(note_f), .note_valid(note_valid_f),
      .beat_tick(beat_tick_f), .playing(playing_f), .done(done_f));

   // ROM models with one cycle of registered read latency
   always @(posedge clk) begin
      rom_data   <= rom4[rom_addr];
      rom_data_f <= romf[rom_addr_f];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected pulse at edge %0d", name, ecnt);
   endtask

   // monitor: pops expectations whenever the DUT presents a strobe
   always @(negedge clk) begin
      ev_t e;
      int  t;
      if (rst_n) begin
         if (note_valid || beat_tick) chk("nv_bt_excl", int'(note_valid & beat_tick), 0);
         if (note_valid) begin
            if (qn.size() == 0) unexpected("note_valid");
            else begin
               e = qn.pop_front();
               chk("nv_edge", ecnt, e.cyc);
               chk("nv_note", int'(note), e.nt);
            end
         end
         if (beat_tick) begin
            if (qt.size() == 0) unexpected("beat_tick");
            else begin
               t = qt.pop_front();
               chk("tick_edge", ecnt, t);
            end
         end
         if (note_valid_f) begin
            if (qf.size() == 0) unexpected("full_note_valid");
            else begin
               e = qf.pop_front();
               chk("full_nv_edge", ecnt, e.cyc);
               chk("full_nv_note", int'(note_f), e.nt);
            end
         end
         if (int'(rom_addr_f) > maxaddr) maxaddr = int'(rom_addr_f);
      end
   end

   task automatic wait_to(input int t);
      while (ecnt < t) @(negedge clk);
   endtask

   // returns at the negedge following the edge that sampled start
   task automatic do_start(input bit full, output int s);
      @(negedge clk);
      if (full) start_f = 1'b1; else start = 1'b1;
      s = ecnt + 1;
      @(negedge clk);
      start = 1'b0;
      start_f = 1'b0;
   endtask

   task automatic push_song(input int s);
      for (int k = 0; k < 4; k++) begin
         qn.push_back('{s + 2 + 8*k, int'(rom4[k])});
         qt.push_back(s + 8 + 8*k);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_note"}, int'(note), 0);
      chk({tag, "_nv"}, int'(note_valid), 0);
      chk({tag, "_tick"}, int'(beat_tick), 0);
      chk({tag, "_playing"}, int'(playing), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_addr"}, int'(rom_addr), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s;
      for (int i = 0; i < 128; i++) begin
         rom4[i] = 5'd0;
         romf[i] = (i < 90) ? 5'((i % 31) + 1) : 5'd0;
      end
      rom4[0] = 5'd1; rom4[1] = 5'd2; rom4[2] = 5'd4; rom4[3] = 5'd8;

      // reset state, then reset mid-HOLD
      repeat (2) @(negedge clk);
      chk_idle("rst");
      rst_n = 1'b1;
      do_start(1'b0, s);
      qn.push_back('{s + 2, 1});
      wait_to(s + 4);
      chk("hold_playing", int'(playing), 1);
      chk("hold_note", int'(note), 1);
      #1 rst_n = 1'b0;
      #1 chk_idle("async_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk_idle("post_rst");

      // normal playback
      do_start(1'b0, s);
      push_song(s);
      wait_to(s + 32);
      chk("s2_done_early", int'(done), 0);
      chk("s2_last_note", int'(note), 8);
      wait_to(s + 33);
      chk("s2_done", int'(done), 1);
      chk("s2_note_cleared", int'(note), 0);
      chk("s2_addr_max", int'(rom_addr), 3);
      chk("s2_playing", int'(playing), 0);
      chk("s2_qn_empty", qn.size(), 0);
      chk("s2_qt_empty", qt.size(), 0);

      // replay from DONE, with an ignored start mid-song
      repeat (3) @(negedge clk);
      do_start(1'b0, s);
      push_song(s);
      chk("s5_done_clr", int'(done), 0);
      wait_to(s + 11);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(s + 33);
      chk("s5_done", int'(done), 1);
      chk("s5_qn_empty", qn.size(), 0);
      chk("s5_qt_empty", qt.size(), 0);

      // pause in HOLD, in FETCH/LATCH, and on the terminal HOLD cycle
      do_start(1'b0, s);
      qn.push_back('{s + 2, 1});  qt.push_back(s + 8);
      qn.push_back('{s + 10, 2}); qt.push_back(s + 21);
      qn.push_back('{s + 23, 4}); qt.push_back(s + 29);
      qn.push_back('{s + 31, 8}); qt.push_back(s + 39);
      wait_to(s + 11);
      pause = 1'b1;
      wait_to(s + 14);
      chk("s3_note_paused", int'(note), 2);
      wait_to(s + 16);
      pause = 1'b0;
      chk("s3_note_paused_end", int'(note), 2);
      wait_to(s + 21);
      pause = 1'b1;
      wait_to(s + 23);
      pause = 1'b0;
      wait_to(s + 36);
      pause = 1'b1;
      wait_to(s + 38);
      pause = 1'b0;
      wait_to(s + 39);
      chk("s3_done_early", int'(done), 0);
      wait_to(s + 40);
      chk("s3_done", int'(done), 1);
      chk("s3_qn_empty", qn.size(), 0);
      chk("s3_qt_empty", qt.size(), 0);

      // abort from DONE, abort with start in IDLE, abort in HOLD
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("s4_abort_done", int'(done), 0);
      chk("s4_abort_addr", int'(rom_addr), 0);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("s4_abort_start_playing", int'(playing), 0);
      chk("s4_abort_start_addr", int'(rom_addr), 0);
      do_start(1'b0, s);
      qn.push_back('{s + 2, 1});  qt.push_back(s + 8);
      qn.push_back('{s + 10, 2}); qt.push_back(s + 16);
      qn.push_back('{s + 18, 4});
      wait_to(s + 19);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("s4_abort_note", int'(note), 0);
      chk("s4_abort_playing", int'(playing), 0);
      chk("s4_abort_hold_addr", int'(rom_addr), 0);
      repeat (20) @(negedge clk);
      chk("s4_still_idle", int'(playing), 0);
      chk("s4_qn_empty", qn.size(), 0);
      chk("s4_qt_empty", qt.size(), 0);

      // full-length song
      do_start(1'b1, s);
      for (int i = 0; i < 94; i++) qf.push_back('{s + 2 + 8*i, int'(romf[i])});
      wait_to(s + 752);
      chk("s6_done_early", int'(done_f), 0);
      wait_to(s + 753);
      chk("s6_done", int'(done_f), 1);
      chk("s6_max_addr", maxaddr, 93);
      chk("s6_final_addr", int'(rom_addr_f), 93);
      chk("s6_qf_empty", qf.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
